// File: rtl/frame_dispatch_ctrl.sv
// Frame dispatcher: reads one 140-bit entry per frame from the parser FIFO, validates
// it and serialises the payload as 16-bit words onto one of 8 valid/ready channels.
module frame_dispatch_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_r_enable,
  input  logic [139:0]     fifo_r_data,
  input  logic [7:0]       ch_ready,
  output logic [7:0]       ch_valid,
  output logic [15:0]      ch_data,
  output logic             ch_last,
  output logic             frame_done,
  output logic             drop_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  // Handshake: a word moves on a rising edge where (ch_valid & ch_ready) != 0. ch_valid is
  // one-hot, so only the selected channel's ready matters; ch_data/ch_last hold until then.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_CAPTURE = 3'd2,
    S_CHECK   = 3'd3,
    S_SEND    = 3'd4
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [139:0]       entry_q, entry_d;
  logic [111:0]       shift_q, shift_d;
  logic [3:0]         rem_q, rem_d;
  logic [15:0]        tmo_q, tmo_d;
  logic               ren_d;
  logic [7:0]         ch_valid_d;
  logic [15:0]        ch_data_d;
  logic               ch_last_d;
  logic               frame_done_d;
  logic               drop_err_d;
  logic               timeout_err_d;
  logic [CNT_W-1:0]   drop_cnt_d;

  logic [3:0]         len_w;
  logic [7:0]         chan_w;
  logic [3:0]         pad_words;
  logic [127:0]       aligned;
  logic               entry_ok;
  logic               xfer;
  logic [CNT_W-1:0]   cnt_inc;

  assign busy = (state_q != S_IDLE);

  always_comb begin
    len_w     = entry_q[139:136];
    chan_w    = entry_q[135:128];
    pad_words = 4'd8 - len_w;
    // Left-justify the payload so word 0 sits in the top 16 bits.
    aligned   = entry_q[127:0] << {pad_words, 4'b0000};
    entry_ok  = (len_w >= 4'd1) && (len_w <= 4'd8) && $onehot(chan_w);
    xfer      = |(ch_valid & ch_ready);
    cnt_inc   = (&drop_cnt) ? drop_cnt : drop_cnt + CNT_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    entry_d       = entry_q;
    shift_d       = shift_q;
    rem_d         = rem_q;
    tmo_d         = tmo_q;
    ren_d         = 1'b0;
    ch_valid_d    = ch_valid;
    ch_data_d     = ch_data;
    ch_last_d     = ch_last;
    frame_done_d  = 1'b0;
    drop_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    drop_cnt_d    = drop_cnt;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          ren_d   = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        entry_d = fifo_r_data;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!entry_ok) begin
          drop_err_d = 1'b1;
          drop_cnt_d = cnt_inc;
          state_d    = S_IDLE;
        end else begin
          shift_d    = aligned[111:0];
          rem_d      = len_w - 4'd1;
          tmo_d      = 16'd0;
          ch_valid_d = chan_w;
          ch_data_d  = aligned[127:112];
          ch_last_d  = (len_w == 4'd1);
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (rem_q != 4'd0) begin
            rem_d     = rem_q - 4'd1;
            shift_d   = {shift_q[95:0], 16'h0000};
            ch_data_d = shift_q[111:96];
            ch_last_d = (rem_q == 4'd1);
            tmo_d     = 16'd0;
          end else begin
            ch_valid_d   = 8'h00;
            ch_last_d    = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          ch_valid_d    = 8'h00;
          ch_last_d     = 1'b0;
          timeout_err_d = 1'b1;
          drop_cnt_d    = cnt_inc;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      entry_q       <= '0;
      shift_q       <= '0;
      rem_q         <= '0;
      tmo_q         <= '0;
      fifo_r_enable <= 1'b0;
      ch_valid      <= '0;
      ch_data       <= '0;
      ch_last       <= 1'b0;
      frame_done    <= 1'b0;
      drop_err      <= 1'b0;
      timeout_err   <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      shift_q       <= shift_d;
      rem_q         <= rem_d;
      tmo_q         <= tmo_d;
      fifo_r_enable <= ren_d;
      ch_valid      <= ch_valid_d;
      ch_data       <= ch_data_d;
      ch_last       <= ch_last_d;
      frame_done    <= frame_done_d;
      drop_err      <= drop_err_d;
      timeout_err   <= timeout_err_d;
      drop_cnt      <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_frame_dispatch_ctrl.sv
// Bench for frame_dispatch_ctrl: FIFO and sink environment, a word-queue model of the
// dispatcher checked every falling edge, and directed scenarios with literal expectations.
module tb_frame_dispatch_ctrl;

  localparam int TO = 16;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  logic           fifo_empty  = 1'b1;
  logic           fifo_r_enable;
  logic [139:0]   fifo_r_data = '0;
  logic [7:0]     ch_ready    = '0;
  logic [7:0]     ch_valid;
  logic [15:0]    ch_data;
  logic           ch_last;
  logic           frame_done;
  logic           drop_err;
  logic           timeout_err;
  logic [CW-1:0]  drop_cnt;
  logic           busy;

  frame_dispatch_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .fifo_empty(fifo_empty),
    .fifo_r_enable(fifo_r_enable), .fifo_r_data(fifo_r_data),
    .ch_ready(ch_ready), .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last),
    .frame_done(frame_done), .drop_err(drop_err), .timeout_err(timeout_err),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [139:0] make_e(input logic [3:0] l, input logic [7:0] c,
                                          input logic [127:0] p);
    return {l, c, p};
  endfunction

  function automatic bit entry_ok(input logic [139:0] e);
    int l;
    l = int'(e[139:136]);
    return (l >= 1) && (l <= 8) && ($countones(e[135:128]) == 1);
  endfunction

  // ---------------- environment + model state ----------------
  logic [139:0] fifo_q[$];
  logic [15:0]  exp_q[$];
  logic [15:0]  obs_q[$];
  int           done_q[$];
  int           ren_q[$];
  logic [7:0]   exp_ch = '0;
  logic [139:0] pend_e = '0;
  int           pend_cnt = 0;
  bit           model_busy = 0;
  bit           exp_done_nx = 0;
  bit           exp_tmo_nx = 0;
  bit           exp_ren_nx = 0;
  int           nt = 0;
  logic [15:0]  model_cnt = '0;
  int           cyc = 0;
  int           vcyc = 0;
  int           tmo_seen = 0;
  int           ready_mode = 0;
  bit           tog = 0;
  logic [127:0] wtmp;
  bit           drop_now;
  bit           done_now;
  bit           tmo_now;

  // ---------------- FIFO/sink driver and scoreboard ----------------
  always @(negedge clk_in) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_ch_valid", ch_valid, 0);
      chk("rst_ch_data", ch_data, 0);
      chk("rst_ch_last", ch_last, 0);
      chk("rst_fifo_r_enable", fifo_r_enable, 0);
      chk("rst_flags", {frame_done, drop_err, timeout_err, busy}, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      exp_q.delete();
      pend_cnt    = 0;
      model_busy  = 0;
      exp_done_nx = 0;
      exp_tmo_nx  = 0;
      nt          = 0;
      model_cnt   = '0;
      ch_ready    = '0;
      exp_ren_nx  = (fifo_q.size() != 0);
      fifo_empty  = (fifo_q.size() == 0);
    end else begin
      done_now = exp_done_nx;
      tmo_now  = exp_tmo_nx;
      drop_now = 0;
      chk("frame_done", frame_done, done_now);
      chk("timeout_err", timeout_err, tmo_now);
      chk("fifo_r_enable", fifo_r_enable, exp_ren_nx);
      if (frame_done) done_q.push_back(cyc);
      if (fifo_r_enable) ren_q.push_back(cyc);
      if (timeout_err) tmo_seen++;
      if (ch_valid != 0) vcyc++;
      exp_done_nx = 0;
      exp_tmo_nx  = 0;
      if (tmo_now && model_cnt != 16'hFFFF) model_cnt++;
      if (done_now || tmo_now) model_busy = 0;
      if (exp_ren_nx) model_busy = 1;

      // An entry popped 3 edges ago has now been judged: dropped or on the wire.
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          if (!entry_ok(pend_e)) begin
            drop_now = 1;
            if (model_cnt != 16'hFFFF) model_cnt++;
            model_busy = 0;
          end else begin
            for (int k = 0; k < int'(pend_e[139:136]); k++) begin
              wtmp = pend_e[127:0] >> (16 * (int'(pend_e[139:136]) - 1 - k));
              exp_q.push_back(wtmp[15:0]);
            end
            exp_ch = pend_e[135:128];
            nt = 0;
          end
        end
      end
      chk("drop_err", drop_err, drop_now);

      if (fifo_r_enable) begin
        if (fifo_q.size() != 0) begin
          fifo_r_data = fifo_q.pop_front();
          pend_e      = fifo_r_data;
          pend_cnt    = 3;
        end else begin
          chk("fifo_underflow", 1, 0);
        end
      end

      // Ready for the coming edge.
      tog = ~tog;
      case (ready_mode)
        1:       ch_ready = 8'hFF;
        2:       ch_ready = tog ? 8'h80 : 8'h7F;
        default: ch_ready = 8'h00;
      endcase

      if (exp_q.size() != 0) begin
        chk("ch_valid", ch_valid, exp_ch);
        chk("ch_data", ch_data, exp_q[0]);
        chk("ch_last", ch_last, (exp_q.size() == 1));
      end else begin
        chk("ch_valid_idle", ch_valid, 0);
      end
      chk("drop_cnt", drop_cnt, model_cnt);
      chk("busy", busy, model_busy);

      if (exp_q.size() != 0) begin
        if ((ch_ready & exp_ch) != 0) begin
          obs_q.push_back(ch_data);
          void'(exp_q.pop_front());
          nt = 0;
          if (exp_q.size() == 0) exp_done_nx = 1;
        end else begin
          nt++;
          if (nt == TO) begin
            exp_tmo_nx = 1;
            exp_q.delete();
            nt = 0;
          end
        end
      end

      exp_ren_nx = !model_busy && (fifo_q.size() != 0);
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [139:0] e);
    fifo_q.push_back(e);
  endtask

  task automatic clear_logs();
    obs_q.delete();
    done_q.delete();
    ren_q.delete();
    vcyc = 0;
    tmo_seen = 0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    repeat (2) @(posedge clk_in);
    while ((fifo_q.size() != 0 || model_busy || pend_cnt != 0) && n < max) begin
      @(posedge clk_in);
      n++;
    end
    if (n >= max) chk("wait_idle_timeout", 1, 0);
    repeat (3) @(posedge clk_in);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(negedge clk_in);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk_in);

    // Three words at full rate on channel 2.
    ready_mode = 1;
    clear_logs();
    push(make_e(4'd3, 8'h04, 128'h1111_2222_3333));
    wait_idle(200);
    chk("t1_words", obs_q.size(), 3);
    chk("t1_w0", obs_q[0], 16'h1111);
    chk("t1_w1", obs_q[1], 16'h2222);
    chk("t1_w2", obs_q[2], 16'h3333);
    chk("t1_done_cnt", done_q.size(), 1);
    chk("t1_read_cnt", ren_q.size(), 1);
    chk("t1_valid_cycles", vcyc, 3);
    chk("t1_first_latency", done_q[0] - ren_q[0], 6);

    // Eight words with the selected ready toggling.
    ready_mode = 2;
    clear_logs();
    push(make_e(4'd8, 8'h80, 128'hA001_A002_A003_A004_A005_A006_A007_A008));
    wait_idle(300);
    chk("t2_words", obs_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_word", obs_q[i], 32'(16'hA001 + i));
    chk("t2_done_cnt", done_q.size(), 1);

    // Four malformed entries, then a good one.
    ready_mode = 1;
    clear_logs();
    push(make_e(4'd2, 8'h06, 128'h1));
    push(make_e(4'd2, 8'h00, 128'h2));
    push(make_e(4'd0, 8'h01, 128'h3));
    push(make_e(4'd9, 8'h01, 128'h4));
    push(make_e(4'd2, 8'h10, 128'h5555_6666));
    wait_idle(300);
    chk("t3_drop_cnt", drop_cnt, 4);
    chk("t3_words", obs_q.size(), 2);
    chk("t3_w0", obs_q[0], 16'h5555);
    chk("t3_w1", obs_q[1], 16'h6666);
    chk("t3_read_cnt", ren_q.size(), 5);

    // Stalled sink: abort after TO SEND cycles.
    ready_mode = 0;
    clear_logs();
    push(make_e(4'd4, 8'h01, 128'h9001_9002_9003_9004));
    wait_idle(300);
    chk("t4_valid_cycles", vcyc, TO);
    chk("t4_timeout_cnt", tmo_seen, 1);
    chk("t4_done_cnt", done_q.size(), 0);
    chk("t4_drop_cnt", drop_cnt, 5);

    // Back-to-back frames.
    ready_mode = 1;
    clear_logs();
    push(make_e(4'd2, 8'h08, 128'h7001_7002));
    push(make_e(4'd3, 8'h20, 128'h8001_8002_8003));
    wait_idle(300);
    chk("t5_read_cnt", ren_q.size(), 2);
    chk("t5_done_cnt", done_q.size(), 2);
    chk("t5_gap", ren_q[1] - done_q[0], 1);
    chk("t5_w0", obs_q[0], 16'h7001);
    chk("t5_w1", obs_q[1], 16'h7002);
    chk("t5_w2", obs_q[2], 16'h8001);
    chk("t5_w4", obs_q[4], 16'h8003);

    // Reset while word 2 of 5 is on the wire.
    ready_mode = 1;
    clear_logs();
    push(make_e(4'd5, 8'h02, 128'hB001_B002_B003_B004_B005));
    push(make_e(4'd1, 8'h02, 128'hC001));
    for (int n = 0; n < 100 && obs_q.size() < 2; n++) @(posedge clk_in);
    chk("t6_reach_word2", obs_q.size(), 2);
    ready_mode = 0;
    repeat (3) @(negedge clk_in);
    chk("t6_pre_rst_data", ch_data, 16'hB003);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", ch_valid, 0);
    chk("t6_rst_data", ch_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cnt", drop_cnt, 0);
    repeat (2) @(negedge clk_in);
    #2 rst_n = 1'b1;
    ready_mode = 1;
    clear_logs();
    wait_idle(200);
    chk("t6_words", obs_q.size(), 1);
    chk("t6_w0", obs_q[0], 16'hC001);
    chk("t6_read_cnt", ren_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
